// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALUop codes, R-type funct values
// and the 4-bit operation codes driven into the ALU.
package exec_pkg;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_ADD_X = 2'b11
  } aluOp_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;

  typedef enum logic [3:0] {
    OP_AND     = 4'b0000,
    OP_OR      = 4'b0001,
    OP_ADD     = 4'b0010,
    OP_SUB     = 4'b0110,
    OP_SLT     = 4'b0111,
    OP_NOR     = 4'b1100,
    OP_ILLEGAL = 4'b1111
  } aluSel_e;

endpackage

// File: rtl/alu_op_decode.sv
// ALU-control decode: maps ALUop and the R-type funct field to a 4-bit
// operation. Purely combinational so other stages can reuse it.
module alu_op_decode
  import exec_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output aluSel_e    alu_sel
);

  always_comb begin
    // NOTE: default assigned first so every path drives alu_sel and no latch is inferred.
    alu_sel = OP_ADD;
    case (aluOp_e'(alu_op))
      ALUOP_ADD, ALUOP_ADD_X: alu_sel = OP_ADD;
      ALUOP_SUB:              alu_sel = OP_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: alu_sel = OP_ADD;
          FUNCT_SUB: alu_sel = OP_SUB;
          FUNCT_AND: alu_sel = OP_AND;
          FUNCT_OR:  alu_sel = OP_OR;
          FUNCT_SLT: alu_sel = OP_SLT;
          FUNCT_NOR: alu_sel = OP_NOR;
          default:   alu_sel = OP_ILLEGAL;
        endcase
      end
      default: alu_sel = OP_ADD;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: ALU-control decode, 32-bit ALU with zero flag, and the
// pc+4 / branch-target adders, all captured into one output register stage.
module alu_exec_unit
  import exec_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int PC_INC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] imm_ext,
  output logic             out_valid,
  output logic [3:0]       alu_sel,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] branch_target
);

  aluSel_e          aluSel;
  logic [WIDTH-1:0] aluResult;
  logic [WIDTH-1:0] pcPlus4Next;
  logic [WIDTH-1:0] branchTargetNext;
  logic             sltBit;

  alu_op_decode uDecode (
    .alu_op (alu_op),
    .funct  (funct),
    .alu_sel(aluSel)
  );

  assign sltBit = $signed(op1) < $signed(op2);

  // Sums wrap modulo 2^WIDTH; the shift drops imm_ext's top two bits.
  assign pcPlus4Next      = pc + WIDTH'(PC_INC);
  assign branchTargetNext = pcPlus4Next + (imm_ext << 2);

  always_comb begin
    aluResult = '0;
    case (aluSel)
      OP_ADD:  aluResult = op1 + op2;
      OP_SUB:  aluResult = op1 - op2;
      OP_AND:  aluResult = op1 & op2;
      OP_OR:   aluResult = op1 | op2;
      OP_NOR:  aluResult = ~(op1 | op2);
      OP_SLT:  aluResult = {{(WIDTH-1){1'b0}}, sltBit};
      default: aluResult = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      alu_sel       <= '0;
      result        <= '0;
      zero          <= 1'b0;
      pc_plus4      <= '0;
      branch_target <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      out_valid <= in_valid;
      if (in_valid) begin
        alu_sel       <= aluSel;
        result        <= aluResult;
        zero          <= (aluResult == '0);
        pc_plus4      <= pcPlus4Next;
        branch_target <= branchTargetNext;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit: reset, R-type, logic ops,
// beq compare, PC adders and back-to-back pipelining.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [31:0] pc;
  logic [31:0] imm_ext;
  logic        out_valid;
  logic [3:0]  alu_sel;
  logic [31:0] result;
  logic        zero;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;

  int checks;
  int errors;

  alu_exec_unit #(.WIDTH(32), .PC_INC(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .alu_op       (alu_op),
    .funct        (funct),
    .op1          (op1),
    .op2          (op2),
    .pc           (pc),
    .imm_ext      (imm_ext),
    .out_valid    (out_valid),
    .alu_sel      (alu_sel),
    .result       (result),
    .zero         (zero),
    .pc_plus4     (pc_plus4),
    .branch_target(branch_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Present one valid input, then land 1 time unit after the capturing edge.
  task automatic drive(input logic [1:0] aop, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic [31:0] im);
    alu_op   = aop;
    funct    = f;
    op1      = a;
    op2      = b;
    pc       = p;
    imm_ext  = im;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    alu_op   = 2'b00;
    funct    = 6'b000000;
    op1      = '0;
    op2      = '0;
    pc       = '0;
    imm_ext  = '0;

    #3;
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_result", result, 32'd0);
    #9 rst_n = 1'b1;

    // Load non-zero state, then pull reset mid-cycle with a capture pending.
    drive(2'b00, 6'b000000, 32'd7, 32'd5, 32'h100, 32'h1);
    check("pre_reset_result", result, 32'd12);
    check("pre_reset_pc_plus4", pc_plus4, 32'h104);
    check("pre_reset_branch_target", branch_target, 32'h108);
    op1 = 32'h55;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("async_reset_alu_sel", {28'b0, alu_sel}, 32'd0);
    check("async_reset_result", result, 32'd0);
    check("async_reset_zero", {31'b0, zero}, 32'd0);
    check("async_reset_pc_plus4", pc_plus4, 32'd0);
    check("async_reset_branch_target", branch_target, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_out_valid", {31'b0, out_valid}, 32'd0);
    check("idle_result_discarded", result, 32'd0);

    // R-type arithmetic and set-less-than.
    drive(2'b10, 6'b100000, 32'd7, 32'd5, 32'h0, 32'h0);
    check("rtype_add_sel", {28'b0, alu_sel}, 32'h2);
    check("rtype_add_result", result, 32'd12);
    check("rtype_add_zero", {31'b0, zero}, 32'd0);
    check("rtype_add_valid", {31'b0, out_valid}, 32'd1);
    drive(2'b10, 6'b100010, 32'd7, 32'd5, 32'h0, 32'h0);
    check("rtype_sub_sel", {28'b0, alu_sel}, 32'h6);
    check("rtype_sub_result", result, 32'd2);
    drive(2'b10, 6'b101010, 32'd7, 32'd5, 32'h0, 32'h0);
    check("rtype_slt_sel", {28'b0, alu_sel}, 32'h7);
    check("rtype_slt_result", result, 32'd0);
    check("rtype_slt_zero", {31'b0, zero}, 32'd1);
    drive(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0);
    check("rtype_slt_signed", result, 32'd1);
    check("rtype_slt_signed_zero", {31'b0, zero}, 32'd0);

    // Bitwise logic and the illegal funct path.
    drive(2'b10, 6'b100100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 32'h0);
    check("and_sel", {28'b0, alu_sel}, 32'h0);
    check("and_result", result, 32'h00F0_00F0);
    drive(2'b10, 6'b100101, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 32'h0);
    check("or_sel", {28'b0, alu_sel}, 32'h1);
    check("or_result", result, 32'hFFF0_FFF0);
    drive(2'b10, 6'b100111, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 32'h0);
    check("nor_sel", {28'b0, alu_sel}, 32'hC);
    check("nor_result", result, 32'h000F_000F);
    drive(2'b10, 6'b000000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 32'h0);
    check("illegal_sel", {28'b0, alu_sel}, 32'hF);
    check("illegal_result", result, 32'd0);
    check("illegal_zero", {31'b0, zero}, 32'd1);

    // beq compare and the alu_op=11 add alias.
    drive(2'b01, 6'b100101, 32'h1234, 32'h1234, 32'h0, 32'h0);
    check("beq_eq_sel", {28'b0, alu_sel}, 32'h6);
    check("beq_eq_result", result, 32'd0);
    check("beq_eq_zero", {31'b0, zero}, 32'd1);
    drive(2'b01, 6'b100101, 32'h1234, 32'h1235, 32'h0, 32'h0);
    check("beq_ne_result", result, 32'hFFFF_FFFF);
    check("beq_ne_zero", {31'b0, zero}, 32'd0);
    drive(2'b11, 6'b100010, 32'd20, 32'd22, 32'h0, 32'h0);
    check("aluop11_sel", {28'b0, alu_sel}, 32'h2);
    check("aluop11_result", result, 32'd42);

    // PC adders: negative offset, wrap, and the discarded imm_ext[31:30].
    drive(2'b00, 6'b000000, 32'h0, 32'h0, 32'h0040_0000, 32'hFFFF_FFFE);
    check("pc_plus4_basic", pc_plus4, 32'h0040_0004);
    check("branch_target_neg", branch_target, 32'h003F_FFFC);
    drive(2'b00, 6'b000000, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFE);
    check("pc_plus4_wrap", pc_plus4, 32'h0000_0000);
    check("branch_target_wrap", branch_target, 32'hFFFF_FFF8);
    drive(2'b00, 6'b000000, 32'h0, 32'h0, 32'h0, 32'h4000_0001);
    check("branch_target_shift_drop", branch_target, 32'h0000_0008);

    // Three back-to-back valid inputs, then idle: outputs must hold.
    drive(2'b00, 6'b000000, 32'd1, 32'd2, 32'h10, 32'h0);
    check("pipe0_valid", {31'b0, out_valid}, 32'd1);
    check("pipe0_result", result, 32'd3);
    drive(2'b01, 6'b000000, 32'd10, 32'd3, 32'h20, 32'h0);
    check("pipe1_valid", {31'b0, out_valid}, 32'd1);
    check("pipe1_result", result, 32'd7);
    drive(2'b10, 6'b100101, 32'h0F, 32'hF0, 32'h30, 32'h1);
    check("pipe2_valid", {31'b0, out_valid}, 32'd1);
    check("pipe2_result", result, 32'hFF);
    in_valid = 1'b0;
    alu_op   = 2'b01;
    op1      = 32'hDEAD;
    op2      = 32'h1;
    pc       = 32'h999;
    @(posedge clk);
    #1;
    check("hold_valid", {31'b0, out_valid}, 32'd0);
    check("hold_result", result, 32'hFF);
    check("hold_sel", {28'b0, alu_sel}, 32'h1);
    check("hold_pc_plus4", pc_plus4, 32'h34);
    check("hold_branch_target", branch_target, 32'h38);
    @(posedge clk);
    #1;
    check("hold2_valid", {31'b0, out_valid}, 32'd0);
    check("hold2_result", result, 32'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
